// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared FSM state type and counter sizing helper for the ccff loader
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_t;

    // Width of a counter that must represent every value 0..max_val inclusive
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - two-entry word buffer that hands out bits MSB-first
module ccff_word_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bit_valid,
    output logic              bit_data,
    input  logic              pop
);
    import ccff_pkg::*;

    localparam int CW = cnt_w(WORD_W);

    logic [WORD_W-1:0] shift_reg;
    logic [CW-1:0]     shift_cnt;
    logic [WORD_W-1:0] hold_reg;
    logic              hold_full;
    logic              accept;
    logic              shift_drain;

    // A flush also closes the input so nothing is accepted into a buffer being emptied
    assign in_ready    = !flush && !hold_full;
    assign accept      = in_valid && in_ready;
    assign bit_valid   = (shift_cnt != '0);
    assign bit_data    = shift_reg[WORD_W-1];
    // Shift register is empty now, or becomes empty on this edge's pop
    assign shift_drain = (shift_cnt == '0) || (pop && (shift_cnt == CW'(1)));

    // Buffer update: refill the shift register on the draining edge so bits flow without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            shift_cnt <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (flush) begin
            shift_cnt <= '0;
            hold_full <= 1'b0;
        end else if (shift_drain) begin
            if (hold_full) begin
                shift_reg <= hold_reg;
                shift_cnt <= CW'(WORD_W);
                hold_full <= 1'b0;
            end else if (accept) begin
                shift_reg <= in_data;
                shift_cnt <= CW'(WORD_W);
            end else if (pop) begin
                shift_cnt <= shift_cnt - CW'(1);
            end
        end else begin
            if (pop) begin
                shift_reg <= shift_reg << 1;
                shift_cnt <= shift_cnt - CW'(1);
            end
            if (accept) begin
                hold_reg  <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - streams bitstream words onto the ccff chain and verifies it by loopback
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_error
);
    import ccff_pkg::*;

    localparam int CNT_W        = cnt_w(CHAIN_LEN);
    // Words beyond this count could never reach the chain, so they are not accepted
    localparam int WORDS_NEEDED = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WCNT_W       = cnt_w(WORDS_NEEDED);

    ccff_state_t       state;
    ccff_state_t       state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic              count_full;
    logic              load_active;
    logic              words_left;
    logic              restart;
    logic              ser_in_ready;
    logic              ser_bit_valid;
    logic              ser_bit;
    logic              pop;
    logic              ref_bit;

    assign count_full  = (bit_cnt == CNT_W'(CHAIN_LEN));
    assign load_active = (state == ST_LOAD) && !count_full;
    assign words_left  = (word_cnt != WCNT_W'(WORDS_NEEDED));
    assign restart     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign bs_ready    = ser_in_ready && words_left;
    assign pop         = load_active && ser_bit_valid;
    assign busy        = (state == ST_LOAD) || (state == ST_CHECK);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .flush     (!load_active),
        .in_data   (bs_data),
        .in_valid  (bs_valid && words_left),
        .in_ready  (ser_in_ready),
        .bit_valid (ser_bit_valid),
        .bit_data  (ser_bit),
        .pop       (pop)
    );

    // FSM state register
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: start is only honoured while idle or done
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)      state_nx = ST_LOAD;
            ST_LOAD:  if (count_full) state_nx = ST_CHECK;
            ST_CHECK: state_nx = ST_DONE;
            ST_DONE:  if (start)      state_nx = ST_LOAD;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Bit and word counters, cleared whenever a new load begins
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (restart) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (pop) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (bs_valid && bs_ready) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end
        end
    end

    // Serial output: head holds its value and the chain freezes whenever no bit is available
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            ref_bit       <= 1'b0;
        end else begin
            ccff_shift_en <= pop;
            if (pop) begin
                ccff_head <= ser_bit;
                if (bit_cnt == '0) begin
                    ref_bit <= ser_bit;
                end
            end
        end
    end

    // Completion status: the first shifted bit is at the tail during CHECK
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else if (state == ST_CHECK) begin
            cfg_done  <= 1'b1;
            cfg_error <= (ccff_tail != ref_bit);
        end else if (restart) begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - self-checking bench for ccff_bitstream_loader with chain models
module tb_ccff_bitstream_loader;

    localparam int WORD_W = 32;
    localparam int LEN_A  = 64;
    localparam int LEN_B  = 40;

    typedef struct {
        logic [31:0] w1;
        logic [31:0] w2;
        int          gap;
        bit          broken;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        prog_reset;
    logic        start_a, start_b;
    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_ready_a, head_a, shift_en_a, tail_a, busy_a, done_a, error_a;
    logic        bs_ready_b, head_b, shift_en_b, tail_b, busy_b, done_b, error_b;
    logic [LEN_A-1:0] chain_a = '0;
    logic [LEN_B-1:0] chain_b = '0;
    bit          broken = 1'b0;
    logic        sel = 1'b0;
    logic        rdy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sh_cnt_a = 0;
    int sh_cnt_b = 0;
    int hs_cnt_b = 0;
    logic exp_q_a[$];
    logic exp_q_b[$];

    ccff_bitstream_loader #(.CHAIN_LEN(LEN_A), .WORD_W(WORD_W)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready_a),
        .ccff_head(head_a), .ccff_shift_en(shift_en_a), .ccff_tail(tail_a),
        .busy(busy_a), .cfg_done(done_a), .cfg_error(error_a)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(LEN_B), .WORD_W(WORD_W)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
        .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready_b),
        .ccff_head(head_b), .ccff_shift_en(shift_en_b), .ccff_tail(tail_b),
        .busy(busy_b), .cfg_done(done_b), .cfg_error(error_b)
    );

    assign tail_a = broken ? chain_a[LEN_A-2] : chain_a[LEN_A-1];
    assign tail_b = chain_b[LEN_B-1];
    assign rdy    = sel ? bs_ready_b : bs_ready_a;

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (shift_en_a) chain_a <= {chain_a[LEN_A-2:0], head_a};
        if (shift_en_b) chain_b <= {chain_b[LEN_B-2:0], head_b};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] outs();
        return {bs_ready_a, head_a, shift_en_a, busy_a, done_a, error_a,
                bs_ready_b, head_b, shift_en_b, busy_b, done_b, error_b};
    endfunction

    always @(negedge prog_clk) begin
        logic e;
        if (!prog_reset) begin
            if (shift_en_a) begin
                sh_cnt_a++;
                if (exp_q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_a_underflow: got shift with no expected bit (cycle %0d)", cyc);
                end else begin
                    e = exp_q_a.pop_front();
                    chk("sb_a_bit", {63'd0, head_a}, {63'd0, e});
                end
            end
            if (shift_en_b) begin
                sh_cnt_b++;
                if (exp_q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_b_underflow: got shift with no expected bit (cycle %0d)", cyc);
                end else begin
                    e = exp_q_b.pop_front();
                    chk("sb_b_bit", {63'd0, head_b}, {63'd0, e});
                end
            end
            if (bs_valid && bs_ready_a) begin
                for (int i = WORD_W - 1; i >= 0; i--) exp_q_a.push_back(bs_data[i]);
            end
            if (bs_valid && bs_ready_b) begin
                hs_cnt_b++;
                for (int i = WORD_W - 1; i >= 0; i--) exp_q_b.push_back(bs_data[i]);
            end
        end
    end

    task automatic pulse_start(input bit which);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge prog_clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        bit hs;
        ok = 1'b0;
        bs_data  = w;
        bs_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge prog_clk);
            hs = rdy;
            @(posedge prog_clk); #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        bs_valid = 1'b0;
    endtask

    task automatic wait_done(input bit which, output int edge_n, output bit ok);
        ok = 1'b0;
        edge_n = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge prog_clk); #1;
            if (which ? done_b : done_a) begin
                ok = 1'b1;
                edge_n = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int hs0;
        int done_edge;
        bit ok;
        sel = 1'b0;
        broken = v.broken;
        sh_cnt_a = 0;
        exp_q_a.delete();
        pulse_start(1'b0);
        chk("start_busy", {63'd0, busy_a}, 64'd1);
        chk("start_status_clr", {62'd0, done_a, error_a}, 64'd0);
        send_word(v.w1, ok);
        chk("hs_w1", {63'd0, ok}, 64'd1);
        hs0 = cyc;
        for (int i = 1; i < v.gap; i++) begin
            @(posedge prog_clk); #1;
        end
        send_word(v.w2, ok);
        chk("hs_w2", {63'd0, ok}, 64'd1);
        wait_done(1'b0, done_edge, ok);
        chk("done_seen", {63'd0, ok}, 64'd1);
        chk("latency", 64'(done_edge - hs0), 64'(v.exp_lat));
        chk("cfg_error", {63'd0, error_a}, {63'd0, v.exp_err});
        chk("shift_cycles", 64'(sh_cnt_a), 64'(LEN_A));
        if (!v.broken) chk("chain_a", chain_a, {v.w1, v.w2});
        chk("ready_in_done", {63'd0, bs_ready_a}, 64'd0);
        chk("sb_a_drained", 64'(exp_q_a.size()), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t reload;
        bit ok;
        int hs0;
        int done_edge;
        logic [31:0] w1b;
        logic [31:0] w2b;

        vecs[0] = '{32'hDEAD_BEEF, 32'h0123_4567,  1, 1'b0, 66, 1'b0};
        vecs[1] = '{32'hA5C3_0F1E, 32'hFFFF_0000, 37, 1'b0, 71, 1'b0};
        vecs[2] = '{32'hA5C3_0F1E, 32'h1234_5678,  1, 1'b1, 66, 1'b1};
        vecs[3] = '{32'h3000_0001, 32'h8000_0000,  1, 1'b1, 66, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 10, 1'b0, 66, 1'b0};
        reload  = '{32'h0F0F_0F0F, 32'hF0F0_F0F0,  1, 1'b0, 66, 1'b0};

        prog_reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        bs_valid = 1'b0;
        bs_data = 32'h0;
        repeat (3) @(posedge prog_clk);
        #1;
        chk("reset_outs", {52'd0, outs()}, 64'd0);
        @(negedge prog_clk);
        prog_reset = 1'b0;

        bs_valid = 1'b1;
        bs_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            @(posedge prog_clk); #1;
            chk("idle_outs", {52'd0, outs()}, 64'd0);
        end
        bs_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        sel = 1'b1;
        sh_cnt_b = 0;
        hs_cnt_b = 0;
        exp_q_b.delete();
        w1b = 32'h89AB_CDEF;
        w2b = 32'h5A5A_1234;
        pulse_start(1'b1);
        send_word(w1b, ok);
        chk("b_hs_w1", {63'd0, ok}, 64'd1);
        hs0 = cyc;
        send_word(w2b, ok);
        chk("b_hs_w2", {63'd0, ok}, 64'd1);
        bs_data = 32'hFFFF_FFFF;
        bs_valid = 1'b1;
        wait_done(1'b1, done_edge, ok);
        chk("b_done_seen", {63'd0, ok}, 64'd1);
        chk("b_latency", 64'(done_edge - hs0), 64'(LEN_B + 2));
        chk("b_cfg_error", {63'd0, error_b}, 64'd0);
        chk("b_shift_cycles", 64'(sh_cnt_b), 64'(LEN_B));
        chk("b_words_accepted", 64'(hs_cnt_b), 64'd2);
        chk("b_chain", {24'd0, chain_b}, {24'd0, w1b, w2b[31:24]});
        chk("b_ready_in_done", {63'd0, bs_ready_b}, 64'd0);
        bs_valid = 1'b0;
        exp_q_b.delete();

        sel = 1'b0;
        broken = 1'b0;
        sh_cnt_a = 0;
        exp_q_a.delete();
        pulse_start(1'b0);
        send_word(32'hDEAD_BEEF, ok);
        send_word(32'hCAFE_F00D, ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sh_cnt_a >= 30) begin
                ok = 1'b1;
                break;
            end
            @(posedge prog_clk); #1;
        end
        chk("reach_shift30", {63'd0, ok}, 64'd1);
        chk("busy_mid_load", {63'd0, busy_a}, 64'd1);
        prog_reset = 1'b1;
        #1;
        chk("async_reset_outs", {52'd0, outs()}, 64'd0);
        @(negedge prog_clk); #1;
        prog_reset = 1'b0;
        exp_q_a.delete();
        exp_q_b.delete();
        chk("post_reset_outs", {52'd0, outs()}, 64'd0);
        run_vec(reload);
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
